// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered divided clock with a tick on
// each rising edge; new divisors take effect only at a period boundary.
module clk_div_prog #(
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 4
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clock_out,
    output logic             tick,
    output logic             pending,
    output logic [WIDTH-1:0] div_cur
);

    localparam logic [WIDTH-1:0] RST_DIV   = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] RST_CLAMP =
        (RESET_DIV < 2) ? WIDTH'(2) : WIDTH'(RESET_DIV);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_active;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] last;
    logic             boundary;
    logic             apply;

    // Divisors below 2 cannot form a period with both phases.
    function automatic logic [WIDTH-1:0] clamp_div(
        input logic [WIDTH-1:0] v
    );
        return (v < WIDTH'(2)) ? WIDTH'(2) : v;
    endfunction

    assign half     = div_active >> 1;
    assign last     = div_active - WIDTH'(1);
    assign boundary = enable && (cnt == last);
    assign apply    = boundary && pending;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt        <= '0;
            clock_out  <= 1'b0;
            tick       <= 1'b0;
            pending    <= 1'b0;
            div_pend   <= RST_DIV;
            div_active <= RST_CLAMP;
        end else begin
            if (enable) begin
                clock_out <= (cnt >= half);
                tick      <= (cnt == half);
                cnt       <= boundary ? '0 : cnt + WIDTH'(1);
            end else begin
                tick <= 1'b0;
            end
            if (apply) begin
                div_active <= clamp_div(div_pend);
            end
            // A load on the boundary applies the old value and keeps
            // the new one pending for the following boundary.
            if (div_load) begin
                div_pend <= div_in;
                pending  <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    assign div_cur = div_active;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: waveform-queue model plus
// directed scenarios with literal expectations.
module tb_clk_div_prog;

    localparam int WIDTH     = 16;
    localparam int RESET_DIV = 4;

    logic             clock_in;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             clock_out;
    logic             tick;
    logic             pending;
    logic [WIDTH-1:0] div_cur;

    int checks   = 0;
    int failures = 0;

    clk_div_prog #(
        .WIDTH    (WIDTH),
        .RESET_DIV(RESET_DIV)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .enable   (enable),
        .div_in   (div_in),
        .div_load (div_load),
        .clock_out(clock_out),
        .tick     (tick),
        .pending  (pending),
        .div_cur  (div_cur)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int unsigned clampf(input int unsigned v);
        return (v < 2) ? 2 : v;
    endfunction

    // Model: each period is queued as its whole waveform (low half,
    // then high half with a tick marker on the first high cycle).
    bit [1:0]    wq[$];
    int unsigned m_cur;
    int unsigned m_pend_val;
    bit          m_pend;
    bit          m_clk;
    bit          m_tick;
    bit          m_valid = 1'b0;

    always @(posedge clock_in) begin
        bit [1:0]    e;
        int unsigned lo;
        if (reset) begin
            wq.delete();
            m_cur      = clampf(RESET_DIV);
            m_pend     = 1'b0;
            m_pend_val = RESET_DIV;
            m_clk      = 1'b0;
            m_tick     = 1'b0;
            m_valid    = 1'b1;
        end else if (m_valid) begin
            if (enable) begin
                if (wq.size() == 0) begin
                    lo = m_cur / 2;
                    for (int i = 0; i < int'(lo); i++) wq.push_back(2'b00);
                    wq.push_back(2'b11);
                    for (int i = 0; i < int'(m_cur - lo) - 1; i++)
                        wq.push_back(2'b01);
                end
                e      = wq.pop_front();
                m_clk  = e[0];
                m_tick = e[1];
                if (wq.size() == 0 && m_pend) begin
                    m_cur  = clampf(m_pend_val);
                    m_pend = 1'b0;
                end
            end else begin
                m_tick = 1'b0;
            end
            if (div_load) begin
                m_pend_val = div_in;
                m_pend     = 1'b1;
            end
        end
    end

    always @(negedge clock_in) begin
        if (m_valid) begin
            chk("m_clock_out", int'(clock_out), int'(m_clk));
            chk("m_tick", int'(tick), int'(m_tick));
            chk("m_pending", int'(pending), int'(m_pend));
            chk("m_div_cur", int'(div_cur), int'(m_cur));
        end
    end

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic wait_tick(input int lim);
        int k = 0;
        while (!tick && k < lim) begin
            step();
            k++;
        end
        chk("wait_tick_timeout", int'(tick), 1);
    endtask

    task automatic wait_div(input int v, input int lim);
        int k = 0;
        while (int'(div_cur) != v && k < lim) begin
            step();
            k++;
        end
        chk("wait_div_timeout", int'(div_cur), v);
    endtask

    task automatic cap(input int n, output logic [7:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            bits[i] = clock_out;
        end
    endtask

    task automatic load(input int v);
        div_in   = WIDTH'(v);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    logic [7:0] co;
    logic [7:0] tk;

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        div_in   = '0;
        div_load = 1'b0;
        step();
        step();
        chk("rst_clock_out", int'(clock_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_div_cur", int'(div_cur), 4);

        // Default N=4 waveform from the first enabled cycle
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            co[i] = clock_out;
            tk[i] = tick;
        end
        chk("n4_clock_out", int'(co), 'hCC);
        chk("n4_tick", int'(tk), 'h44);

        // Load 5 mid-period
        step();
        load(5);
        chk("ld5_pending", int'(pending), 1);
        chk("ld5_div_cur_before", int'(div_cur), 4);
        step();
        chk("ld5_pending_hold", int'(pending), 1);
        step();
        chk("ld5_div_cur", int'(div_cur), 5);
        chk("ld5_pending_clr", int'(pending), 0);
        step();
        wait_tick(20);
        cap(5, co);
        chk("n5_pattern", int'(co[4:0]), 'h07);

        // Enable dropped in the high phase
        step();
        wait_tick(20);
        step();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_clock_out", int'(clock_out), 1);
            chk("hold_tick", int'(tick), 0);
        end
        enable = 1'b1;

        // Load on the boundary with a value already pending
        step();
        wait_tick(20);
        div_in   = WIDTH'(3);
        div_load = 1'b1;
        step();
        div_in = WIDTH'(6);
        step();
        div_load = 1'b0;
        chk("bnd_div_cur", int'(div_cur), 3);
        chk("bnd_pending", int'(pending), 1);
        step();
        step();
        step();
        chk("bnd_div_cur_next", int'(div_cur), 6);
        chk("bnd_pending_clr", int'(pending), 0);

        // Clamp of 0 and 1
        load(0);
        wait_div(2, 20);
        step();
        wait_tick(20);
        cap(8, co);
        chk("n0_pattern", int'(co), 'h55);
        load(1);
        for (int k = 0; k < 20 && pending; k++) step();
        chk("n1_pending", int'(pending), 0);
        chk("n1_div_cur", int'(div_cur), 2);

        // Reset while a divisor is pending at cnt=2
        load(7);
        wait_div(7, 20);
        load(9);
        step();
        chk("prst_pending", int'(pending), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("prst_clock_out", int'(clock_out), 0);
        chk("prst_pending", int'(pending), 0);
        chk("prst_div_cur", int'(div_cur), 4);
        chk("prst_tick", int'(tick), 0);
        for (int i = 0; i < 8; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
